// File: rtl/ifetch_pkg.sv
// Shared widths, the prefetch entry type and the default reset PC for the
// instruction-fetch front end.
package ifetch_pkg;

    localparam int unsigned ADDR_W  = 16;
    localparam int unsigned INSTR_W = 16;

    localparam logic [ADDR_W-1:0] RESET_PC_DEFAULT = 16'h0000;

    typedef struct packed {
        logic [ADDR_W-1:0]  pc;
        logic [INSTR_W-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/ifetch_prefetch_if.sv
// Bus bundle between the fetch unit, memory port A and the decode stage.
// master = fetch unit side, slave = memory/decode/control side.
interface ifetch_prefetch_if;
    import ifetch_pkg::*;

    logic [ADDR_W-1:0]  mem_addr;
    logic               mem_we;
    logic [INSTR_W-1:0] mem_rdata;
    logic               fetch_en;
    logic               redirect_valid;
    logic [ADDR_W-1:0]  redirect_pc;
    logic               instr_valid;
    logic [INSTR_W-1:0] instr;
    logic [ADDR_W-1:0]  instr_pc;
    logic               instr_ready;

    modport master (
        output mem_addr, mem_we, instr_valid, instr, instr_pc,
        input  mem_rdata, fetch_en, redirect_valid, redirect_pc, instr_ready
    );

    modport slave (
        input  mem_addr, mem_we, instr_valid, instr, instr_pc,
        output mem_rdata, fetch_en, redirect_valid, redirect_pc, instr_ready
    );

endinterface

// File: rtl/ifetch_fifo.sv
// DEPTH-entry synchronous FIFO of fetch entries with flush; flush overrides
// push and pop in the same cycle.
module ifetch_fifo
    import ifetch_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rstz,
    input  logic                   push,
    input  logic                   pop,
    input  logic                   flush,
    input  fetch_entry_t           wdata,
    output fetch_entry_t           rdata,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    fetch_entry_t    entries [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;

    always_ff @(posedge clk or negedge rstz) begin
        if (!rstz) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push && !flush) entries[wr_ptr] <= wdata;
    end

    assign rdata = entries[rd_ptr];
    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);

endmodule

// File: rtl/ifetch_prefetch.sv
// Instruction-fetch front end: fetch PC, prefetch FIFO, redirect flush.
// Optional macro IFETCH_BYPASS_EN gives zero-latency delivery on an empty FIFO.
module ifetch_prefetch
    import ifetch_pkg::*;
#(
    parameter int unsigned       DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int unsigned       PC_STEP  = 2
) (
    input  logic                clk,
    input  logic                rstz,
    ifetch_prefetch_if.master   bus
);

    localparam int unsigned CW = $clog2(DEPTH) + 1;

    logic [ADDR_W-1:0] fpc;
    logic              pop_fifo;
    logic              push;
    logic              push_fifo;
    logic              out_valid;
    fetch_entry_t      out_entry;
    fetch_entry_t      head;
    logic [CW-1:0]     count;
    logic              full;
    logic              empty;

    ifetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rstz  (rstz),
        .push  (push_fifo),
        .pop   (pop_fifo),
        .flush (bus.redirect_valid),
        .wdata ('{pc: fpc, instr: bus.mem_rdata}),
        .rdata (head),
        .count (count),
        .full  (full),
        .empty (empty)
    );

    always_comb begin
        pop_fifo  = !empty && bus.instr_ready;
        // A pop frees a slot this cycle, so a full FIFO can still accept.
        push      = bus.fetch_en && !bus.redirect_valid && (!full || pop_fifo);
        push_fifo = push;
        out_valid = !empty;
        out_entry = empty ? '0 : head;
`ifdef IFETCH_BYPASS_EN
        if (empty && bus.fetch_en && !bus.redirect_valid && bus.instr_ready) begin
            push_fifo = 1'b0;
            out_valid = 1'b1;
            out_entry = '{pc: fpc, instr: bus.mem_rdata};
        end
`endif
    end

    always_ff @(posedge clk or negedge rstz) begin
        if (!rstz) begin
            fpc <= RESET_PC;
        end else if (bus.redirect_valid) begin
            fpc <= bus.redirect_pc;
        end else if (push) begin
            fpc <= fpc + ADDR_W'(PC_STEP);
        end
    end

    assign bus.mem_addr    = fpc;
    assign bus.mem_we      = 1'b0;
    assign bus.instr_valid = out_valid;
    assign bus.instr       = out_entry.instr;
    assign bus.instr_pc    = out_entry.pc;

    count_bound: assert property (@(posedge clk) disable iff (!rstz) count <= CW'(DEPTH));

endmodule
